// File: rtl/if_id_latch.sv
// IF/ID pipeline latch with RUN/HALTED state, flush/stall control and bubble insertion.
// Optional stall/flush performance counters are enabled by defining IF_ID_PERF_EN.
module if_id_latch (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic [31:0] pc_plus4_IF,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr_IF_ID,
  output logic [5:0]  opcode_IF_ID,
  output logic [5:0]  func_IF_ID,
  output logic [4:0]  rs_IF_ID,
  output logic [4:0]  rt_IF_ID,
  output logic [4:0]  rd_IF_ID,
  output logic [4:0]  shamt_IF_ID,
  output logic [15:0] imm_IF_ID,
  output logic [31:0] pc_plus4_IF_ID,
  output logic        valid_IF_ID,
  output logic        halt_seen
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  localparam logic [5:0] OP_HALT = 6'b111111;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q,    pc_d;
  logic        valid_q, valid_d;

  // Priority: flush > stall > HALTED hold > ihit capture > bubble.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = RUN;
      instr_d = '0;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (!stall && (state_q == RUN)) begin
      if (ihit) begin
        instr_d = imemload;
        pc_d    = pc_plus4_IF;
        valid_d = 1'b1;
        if (imemload[31:26] == OP_HALT) state_d = HALTED;
      end else begin
        instr_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_IF_ID    = instr_q;
  assign pc_plus4_IF_ID = pc_q;
  assign valid_IF_ID    = valid_q;
  assign halt_seen      = (state_q == HALTED);

  assign opcode_IF_ID = instr_q[31:26];
  assign rs_IF_ID     = instr_q[25:21];
  assign rt_IF_ID     = instr_q[20:16];
  assign rd_IF_ID     = instr_q[15:11];
  assign shamt_IF_ID  = instr_q[10:6];
  assign func_IF_ID   = instr_q[5:0];
  assign imm_IF_ID    = instr_q[15:0];

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !flush && (state_q == RUN) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && valid_q && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_latch.sv
// Self-checking bench for if_id_latch: directed scenarios plus randomized traffic
// compared against a behavioural model of the latch rules.
module tb_if_id_latch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] pc_plus4_IF;
  logic        stall;
  logic        flush;
  logic [31:0] instr_IF_ID;
  logic [5:0]  opcode_IF_ID;
  logic [5:0]  func_IF_ID;
  logic [4:0]  rs_IF_ID;
  logic [4:0]  rt_IF_ID;
  logic [4:0]  rd_IF_ID;
  logic [4:0]  shamt_IF_ID;
  logic [15:0] imm_IF_ID;
  logic [31:0] pc_plus4_IF_ID;
  logic        valid_IF_ID;
  logic        halt_seen;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  if_id_latch dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .imemload       (imemload),
    .pc_plus4_IF    (pc_plus4_IF),
    .stall          (stall),
    .flush          (flush),
    .instr_IF_ID    (instr_IF_ID),
    .opcode_IF_ID   (opcode_IF_ID),
    .func_IF_ID     (func_IF_ID),
    .rs_IF_ID       (rs_IF_ID),
    .rt_IF_ID       (rt_IF_ID),
    .rd_IF_ID       (rd_IF_ID),
    .shamt_IF_ID    (shamt_IF_ID),
    .imm_IF_ID      (imm_IF_ID),
    .pc_plus4_IF_ID (pc_plus4_IF_ID),
    .valid_IF_ID    (valid_IF_ID),
    .halt_seen      (halt_seen)
`ifdef IF_ID_PERF_EN
    ,
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [31:0] m_instr, m_pc, m_stall_cnt, m_flush_cnt;
  logic        m_valid, m_halted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_instr = 0; m_pc = 0; m_valid = 0; m_halted = 0;
    m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  // Apply one rising edge of the latch rules to the model using the current inputs.
  task automatic model_edge();
    if (stall && !flush && !m_halted && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (flush && m_valid && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    if (flush) begin
      m_instr = 0; m_pc = 0; m_valid = 0; m_halted = 0;
    end else if (stall || m_halted) begin
      // everything holds
    end else if (ihit) begin
      m_instr = imemload; m_pc = pc_plus4_IF; m_valid = 1;
      if ((imemload / 32'h0400_0000) == 63) m_halted = 1;
    end else begin
      m_instr = 0; m_valid = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_instr"},  instr_IF_ID,    m_instr);
    check_eq({tag, "_pc"},     pc_plus4_IF_ID, m_pc);
    check_eq({tag, "_valid"},  {31'd0, valid_IF_ID}, {31'd0, m_valid});
    check_eq({tag, "_halt"},   {31'd0, halt_seen},   {31'd0, m_halted});
    check_eq({tag, "_opcode"}, {26'd0, opcode_IF_ID}, m_instr / 32'h0400_0000);
    check_eq({tag, "_rs"},     {27'd0, rs_IF_ID},     (m_instr / 32'h0020_0000) % 32);
    check_eq({tag, "_rt"},     {27'd0, rt_IF_ID},     (m_instr / 32'h0001_0000) % 32);
    check_eq({tag, "_rd"},     {27'd0, rd_IF_ID},     (m_instr / 32'h0000_0800) % 32);
    check_eq({tag, "_shamt"},  {27'd0, shamt_IF_ID},  (m_instr / 32'h0000_0040) % 32);
    check_eq({tag, "_func"},   {26'd0, func_IF_ID},   m_instr % 64);
    check_eq({tag, "_imm"},    {16'd0, imm_IF_ID},    m_instr % 65536);
`ifdef IF_ID_PERF_EN
    check_eq({tag, "_stallcnt"}, stall_count, m_stall_cnt);
    check_eq({tag, "_flushcnt"}, flush_count, m_flush_cnt);
`endif
  endtask

  task automatic step(input string tag, input logic h, input logic [31:0] im,
                      input logic [31:0] pc, input logic st, input logic fl);
    ihit = h; imemload = im; pc_plus4_IF = pc; stall = st; flush = fl;
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] base_stall;
    nRST = 1'b0; ihit = 0; imemload = 0; pc_plus4_IF = 0; stall = 0; flush = 0;
    model_reset();
    #12;
    check_all("reset");
    #1 nRST = 1'b1;

    // Basic capture with field decode
    step("cap", 1, 32'h2001_0005, 32'h4, 0, 0);
    check_eq("cap_opcode_k", {26'd0, opcode_IF_ID}, 32'h08);
    check_eq("cap_rt_k",     {27'd0, rt_IF_ID},     32'd1);
    check_eq("cap_imm_k",    {16'd0, imm_IF_ID},    32'h5);
    check_eq("cap_valid_k",  {31'd0, valid_IF_ID},  32'd1);

    // Stall holds for three cycles
    step("cap2", 1, 32'h0022_1820, 32'h8, 0, 0);
    base_stall = m_stall_cnt;
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 32'h1234_5678, 32'hC, 1, 0);
      check_eq("stall_instr_k", instr_IF_ID, 32'h0022_1820);
    end
    check_eq("stall_modelcnt_k", m_stall_cnt, base_stall + 3);

    // Flush beats stall
    step("flush_stall", 1, 32'h2001_0005, 32'h10, 1, 1);
    check_eq("fs_instr_k", instr_IF_ID,    32'h0);
    check_eq("fs_pc_k",    pc_plus4_IF_ID, 32'h0);

    // HALT capture, hold, then flush out
    step("halt", 1, 32'hFFFF_FFFF, 32'h14, 0, 0);
    check_eq("halt_k", {31'd0, halt_seen}, 32'd1);
    step("halt_hold", 1, 32'h2001_0005, 32'h18, 0, 0);
    check_eq("halt_hold_k", instr_IF_ID, 32'hFFFF_FFFF);
    step("halt_flush", 0, 32'h0, 32'h0, 0, 1);
    check_eq("halt_flush_k", {31'd0, halt_seen}, 32'd0);

    // Bubble keeps pc
    step("pre_bub", 1, 32'h0022_1820, 32'h20, 0, 0);
    step("bubble", 0, 32'h2001_0005, 32'h24, 0, 0);
    check_eq("bubble_pc_k", pc_plus4_IF_ID, 32'h20);

    // Asynchronous reset while HALTED
    step("halt2", 1, 32'hFC00_0000, 32'h30, 0, 0);
    #2 nRST = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge CLK);
    #1;
    check_all("rst_hold");
    nRST = 1'b1;
    step("post_rst_idle", 0, 32'h2001_0005, 32'h34, 0, 0);
    step("post_rst_cap", 1, 32'h2001_0005, 32'h38, 0, 0);
    check_eq("post_rst_cap_k", instr_IF_ID, 32'h2001_0005);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      logic [31:0] im;
      im = $urandom;
      if ($urandom_range(0, 9) == 0) im = im | 32'hFC00_0000;
      step("rand", ($urandom_range(0, 3) != 0), im, $urandom,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 49) == 0) begin
        #2 nRST = 1'b0;
        #1;
        model_reset();
        check_all("rand_rst");
        #1 nRST = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
